// File: rtl/gs_butterfly.sv
// rtl/gs_butterfly.sv - pipelined Gentleman-Sande radix-2 butterfly for the inverse NTT
//
// Computes A = (a + b) mod Q and B = ((a - b) * w) mod Q. One operand triple
// is accepted per cycle and its result appears exactly LATENCY cycles later.
// There is no backpressure.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   a, b, w are valid this cycle
//   a, b       upper / lower operand, < Q
//   w          inverse twiddle factor, < Q
//   out_valid  A and B carry a result this cycle
//   A          (a + b) mod Q, held while out_valid is low
//   B          ((a - b) * w) mod Q, held while out_valid is low
//
// Datapath: LATENCY-4 input padding registers, then the stage-1 add/sub,
// the multiply, the Barrett quotient estimate, and the final correction into
// the output registers. Barrett uses k = W and assumes 2^(W-1) <= Q < 2^W.
module gs_butterfly #(
  parameter int          W       = 30,
  parameter int unsigned Q       = 1073479681,
  parameter int          LATENCY = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  output logic         out_valid,
  output logic [W-1:0] A,
  output logic [W-1:0] B
);

  localparam int PAD = LATENCY - 4;
  localparam logic [W:0]   QE   = (W+1)'(Q);
  localparam logic [W+1:0] QW2  = (W+2)'(Q);
  localparam logic [63:0]  MU64 = (64'd1 << (2*W)) / 64'(Q);
  localparam logic [W+1:0] MU   = (W+2)'(MU64);

  // Valid bits; reset clears every in-flight result immediately.
  logic [LATENCY-1:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[LATENCY-2:0], in_valid};
  end

  assign out_valid = vld[LATENCY-1];

  // Padding registers sit in front of the arithmetic so the datapath is the
  // same for every LATENCY.
  logic [W-1:0] pa, pb, pw;

  if (PAD > 0) begin : g_pad
    logic [W-1:0] ra [PAD];
    logic [W-1:0] rb [PAD];
    logic [W-1:0] rw [PAD];

    always_ff @(posedge clk) begin
      ra[0] <= a;
      rb[0] <= b;
      rw[0] <= w;
      for (int i = 1; i < PAD; i++) begin
        ra[i] <= ra[i-1];
        rb[i] <= rb[i-1];
        rw[i] <= rw[i-1];
      end
    end

    assign pa = ra[PAD-1];
    assign pb = rb[PAD-1];
    assign pw = rw[PAD-1];
  end else begin : g_nopad
    assign pa = a;
    assign pb = b;
    assign pw = w;
  end

  // Stage 1: sum and difference, each reduced by a single subtraction of Q.
  // Adding Q before subtracting keeps the difference non-negative.
  logic [W:0]   s_c, d_c;
  logic [W-1:0] s1, d1, w1;

  assign s_c = {1'b0, pa} + {1'b0, pb};
  assign d_c = {1'b0, pa} + QE - {1'b0, pb};

  always_ff @(posedge clk) begin
    s1 <= (s_c >= QE) ? W'(s_c - QE) : W'(s_c);
    d1 <= (d_c >= QE) ? W'(d_c - QE) : W'(d_c);
    w1 <= pw;
  end

  // Stage 2: full product, p < Q^2 < 2^(2W).
  logic [2*W-1:0] p_c, p2;
  logic [W-1:0]   s2;

  assign p_c = {{W{1'b0}}, d1} * {{W{1'b0}}, w1};

  always_ff @(posedge clk) begin
    p2 <= p_c;
    s2 <= s1;
  end

  // Stage 3: Barrett quotient estimate q3 = ((p >> (W-1)) * MU) >> (W+1).
  // q3 undershoots the true quotient by at most 2, so the remainder is < 3Q.
  // Only the low W+2 bits of p are needed to form that remainder.
  logic [W:0]     q1_c;
  logic [2*W+2:0] q2_c;
  logic [W+1:0]   q3, p3;
  logic [W-1:0]   s3;
  logic           unused_q2;

  assign q1_c      = p2[2*W-1:W-1];
  assign q2_c      = {{(W+2){1'b0}}, q1_c} * {{(W+1){1'b0}}, MU};
  assign unused_q2 = ^q2_c[W:0];

  always_ff @(posedge clk) begin
    q3 <= q2_c[2*W+2:W+1];
    p3 <= p2[W+1:0];
    s3 <= s2;
  end

  // Stage 4: remainder computed modulo 2^(W+2) (exact since it is < 3Q),
  // then up to two corrections.
  logic [W+1:0] r_c, r1_c, r2_c;

  assign r_c  = p3 - q3 * QW2;
  assign r1_c = (r_c  >= QW2) ? r_c  - QW2 : r_c;
  assign r2_c = (r1_c >= QW2) ? r1_c - QW2 : r1_c;

  // Output registers load only with a valid result and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A <= '0;
      B <= '0;
    end else if (vld[LATENCY-2]) begin
      A <= s3;
      B <= W'(r2_c);
    end
  end

endmodule

// File: tb/tb_gs_butterfly.sv
// tb/tb_gs_butterfly.sv - randomized self-checking bench for gs_butterfly at LATENCY 12, 4 and 16
module tb_gs_butterfly;

  localparam int          W    = 30;
  localparam int unsigned Q    = 1073479681;
  localparam int          NI   = 3;
  localparam int          MAXC = 32768;
  localparam int          LAT [NI] = '{12, 4, 16};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b, w;
  logic         ov [NI];
  logic [W-1:0] oa [NI];
  logic [W-1:0] ob [NI];

  gs_butterfly #(.W(W), .Q(Q), .LATENCY(12)) u_l12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .w(w),
    .out_valid(ov[0]), .A(oa[0]), .B(ob[0]));

  gs_butterfly #(.W(W), .Q(Q), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .w(w),
    .out_valid(ov[1]), .A(oa[1]), .B(ob[1]));

  gs_butterfly #(.W(W), .Q(Q), .LATENCY(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .w(w),
    .out_valid(ov[2]), .A(oa[2]), .B(ob[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_a(input longint unsigned x, input longint unsigned y);
    return (x + y) % Q;
  endfunction

  function automatic longint unsigned ref_b(input longint unsigned x, input longint unsigned y,
                                            input longint unsigned t);
    return (((x + Q - y) % Q) * t) % Q;
  endfunction

  // History of accepted inputs indexed by clock edge, with their expected results.
  bit              hv [MAXC];
  longint unsigned ha [MAXC];
  longint unsigned hb [MAXC];
  longint unsigned hold_a [NI];
  longint unsigned hold_b [NI];
  int ec = 0;

  // Drive one cycle of input, then check every instance against the model.
  task automatic step(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [W-1:0] ww);
    in_valid = v;
    a = aa;
    b = bb;
    w = ww;
    @(posedge clk);
    hv[ec] = v && !rst;
    ha[ec] = ref_a(aa, bb);
    hb[ec] = ref_b(aa, bb, ww);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int idx;
      bit ev;
      idx = ec - (LAT[i] - 1);
      ev  = (idx >= 0) ? hv[idx] : 1'b0;
      if (ev) begin
        hold_a[i] = ha[idx];
        hold_b[i] = hb[idx];
      end
      check($sformatf("L%0d out_valid @%0d", LAT[i], ec), ov[i], ev);
      check($sformatf("L%0d A @%0d", LAT[i], ec), oa[i], hold_a[i]);
      check($sformatf("L%0d B @%0d", LAT[i], ec), ob[i], hold_b[i]);
    end
    ec++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0);
  endtask

  // Asynchronous reset between clock edges; called just after a falling edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d async rst out_valid", LAT[i]), ov[i], 0);
      check($sformatf("L%0d async rst A", LAT[i]), oa[i], 0);
      check($sformatf("L%0d async rst B", LAT[i]), ob[i], 0);
      hold_a[i] = 0;
      hold_b[i] = 0;
    end
    for (int j = 0; j < ec; j++) hv[j] = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rop();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(Q - 1);
      default: return W'($urandom_range(0, Q - 1));
    endcase
  endfunction

  localparam longint unsigned TV [4][5] = '{
    '{12345,  41524, 95267, 53869, 440643250},
    '{Q - 1,  1,     1,     0,     1073479679},
    '{3,      5,     Q - 1, 8,     2},
    '{7,      7,     99,    14,    0}
  };

  initial begin
    int n, cnt, sent;
    int pos [4];
    longint unsigned ga [4];
    longint unsigned gb [4];
    logic [W-1:0] ra, rb, rw;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    w = '0;
    for (int i = 0; i < NI; i++) begin
      hold_a[i] = 0;
      hold_b[i] = 0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d reset out_valid", LAT[i]), ov[i], 0);
      check($sformatf("L%0d reset A", LAT[i]), oa[i], 0);
      check($sformatf("L%0d reset B", LAT[i]), ob[i], 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single triple: latency, one-cycle pulse, held result.
    step(1'b1, 30'd5, 30'd3, 30'd7);
    n = 0;
    while (n < 20) begin
      idle(1);
      n++;
      if (ov[0]) break;
    end
    check("first latency", n, 11);
    check("first A", oa[0], 8);
    check("first B", ob[0], 14);
    idle(1);
    check("pulse width", ov[0], 0);
    check("held A", oa[0], 8);
    check("held B", ob[0], 14);
    idle(12);

    // Four back-to-back directed triples.
    for (int k = 0; k < 4; k++) step(1'b1, W'(TV[k][0]), W'(TV[k][1]), W'(TV[k][2]));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (ov[0] && cnt < 4) begin
        pos[cnt] = k;
        ga[cnt]  = oa[0];
        gb[cnt]  = ob[0];
        cnt++;
      end
    end
    check("burst count", cnt, 4);
    if (cnt == 4) begin
      check("burst contiguous", pos[3] - pos[0], 3);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("burst A%0d", k), ga[k], TV[k][3]);
        check($sformatf("burst B%0d", k), gb[k], TV[k][4]);
      end
    end

    // Alternating valid.
    for (int k = 0; k < 20; k++) step((k % 2) == 0, rop(), rop(), rop());
    idle(18);

    // Reset with five results in flight.
    for (int k = 0; k < 5; k++) step(1'b1, rop(), rop(), rop());
    do_reset();
    idle(20);
    step(1'b1, rop(), rop(), rop());
    idle(18);

    // Random regression.
    sent = 0;
    while (sent < 10000) begin
      bit v;
      v  = 1'($urandom_range(0, 1));
      ra = rop();
      rb = rop();
      rw = rop();
      case ($urandom_range(0, 15))
        0: rb = ra;
        1: rb = (ra == 0) ? '0 : W'(Q - ra);
        2: begin ra = W'(Q - 1); rb = W'(Q - 1); rw = W'(Q - 1); end
        default: ;
      endcase
      step(v, ra, rb, rw);
      if (v) sent++;
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gs_butterfly.md
# gs_butterfly

Pipelined Gentleman–Sande (decimation-in-frequency) radix-2 butterfly for the inverse-NTT datapath. It is the counterpart of the forward Cooley–Tukey butterfly and computes A = (a + b) mod Q and B = ((a − b) · w) mod Q. It accepts one operand triple per cycle and produces results a fixed LATENCY cycles later, with a valid bit travelling alongside the data. The inverse-NTT stage controller instantiates it in place of the CT butterfly.

## Interface
- W, 30: operand/result width in bits.
- Q, 1073479681: modulus; must satisfy Q < 2^W. All inputs are < Q.
- LATENCY, 12: cycles from an accepted input to its result; legal range 4..16.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b, w are valid this cycle.
- a  input  W  upper operand, < Q.
- b  input  W  lower operand, < Q.
- w  input  W  inverse twiddle factor, < Q.
- out_valid  output  1  A and B carry a result this cycle.
- A  output  W  (a + b) mod Q.
- B  output  W  ((a − b) · w) mod Q.

## Operation
- No backpressure: one input per cycle, and every accepted input yields exactly one result.
- Stage 1 (registered): s = a + b (W+1 bits) and d = a − b + Q (W+1 bits); each is conditionally reduced by one subtraction of Q, so s_r < Q and d_r < Q.
- Multiply: p = d_r · w (2W bits) is computed over pipelined stages.
- Reduction: exact modular reduction of p (for example Barrett with a precomputed constant) ends with one or two conditional subtractions, so B < Q always.
- s_r goes through a delay line so that A and B leave the block together.
- Any pipeline stages beyond those the datapath needs are padding registers. The result must not depend on how the stages are split.
- The valid bit shift register is LATENCY deep. Data registers may load when valid is low; only the output registers are required to hold their value.
- out_valid = 0: A and B hold the last valid result. They are not cleared.
- Inputs of Q or larger are outside the contract, and the results for them are unspecified.

## Timing
- Reset (asynchronous assert): out_valid = 0, A = 0, B = 0, and every internal valid bit = 0, all immediately and without waiting for a clock edge.
- Reset release: the first input is accepted on the first rising edge at which rst is low.
- Latency: in_valid high at the edge of cycle t gives out_valid high, with the results, at cycle t+LATENCY.
- Throughput: 1 result per cycle. Back-to-back inputs produce back-to-back outputs in order. Gaps in in_valid reappear as identical gaps in out_valid.
- Reset during operation: all in-flight results are discarded. No out_valid pulse may appear for any input accepted before reset, including inputs accepted in the same cycle that rst asserts.
- Operand boundaries:
  - a = b gives B = 0.
  - a + b = Q gives A = 0.
  - w = 0 gives B = 0.
  - The extreme operands a = b = w = Q−1 must not overflow any intermediate value.

## Test plan
- Reset, then send a=5, b=3, w=7 in one cycle → 12 cycles later out_valid=1 for exactly one cycle with A=8, B=14; then out_valid=0 with A=8 and B=14 held.
- Send 4 consecutive cycles:
  - (12345, 41524, 95267) → A=53869, B=440643250
  - (Q−1, 1, 1) → A=0, B=1073479679
  - (3, 5, Q−1) → A=8, B=2
  - (7, 7, 99) → A=14, B=0
  
  The four results must appear on 4 consecutive out_valid cycles in this order.
- Alternate in_valid 1/0 for 20 cycles with random operands < Q → out_valid shows the same pattern delayed by 12 cycles, and each result matches the reference model.
- Assert rst asynchronously (between clock edges) while 5 results are in flight → out_valid, A and B go to 0 at once. No out_valid pulse appears in the 20 cycles after release. A new input after release returns its result after 12 cycles.
- Random regression of 10,000 triples including a=b=w=Q−1, a=0, b=0 and w=0, with in_valid random → every result matches the modular reference model. Repeat with LATENCY=4 and LATENCY=16.
